hazard_ctrl_mc: RTL and testbench

Parametrised hazard controller for the 5-stage RISC-V pipeline (F/D/E/M/W). It adds a multi-cycle execute unit (mul/div) that holds E for MC_LAT cycles, an optional no-forwarding mode, an E-stage stall output, an M-stage bubble output and a saturating stall-cycle counter. It sits beside the datapath and controller and drives every pipeline register's stall and flush inputs.

---
 rtl/hazard_ctrl_mc_if.sv | 48 ++++
 rtl/hazard_ctrl_mc.sv | 139 +++++++++++++
 tb/tb_hazard_ctrl_mc.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_mc_if.sv
// Hazard controller bus: pipeline-stage register fields in, stall/flush/forward controls out.
interface hazard_ctrl_mc_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
);
  // Decode-stage sources
  logic [REG_AW-1:0] Rs1D;
  logic [REG_AW-1:0] Rs2D;
  // Execute-stage sources and destinations
  logic [REG_AW-1:0] Rs1E;
  logic [REG_AW-1:0] Rs2E;
  logic [REG_AW-1:0] RdE;
  logic [REG_AW-1:0] RdM;
  logic [REG_AW-1:0] RdW;
  logic              RegWriteE;
  logic              RegWriteM;
  logic              RegWriteW;
  logic              LoadE;
  logic              McStartE;
  logic              PCSrcE;
  // Controls back to the datapath
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic              StallF;
  logic              StallD;
  logic              StallE;
  logic              FlushD;
  logic              FlushE;
  logic              FlushM;
  logic              mc_busy;
  logic [CNT_W-1:0]  stall_count;

  // Datapath/controller side
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteE, RegWriteM, RegWriteW, LoadE, McStartE, PCSrcE,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE,
    input  FlushD, FlushE, FlushM, mc_busy, stall_count
  );

  // Hazard controller side
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteE, RegWriteM, RegWriteW, LoadE, McStartE, PCSrcE,
    output ForwardAE, ForwardBE, StallF, StallD, StallE,
    output FlushD, FlushE, FlushM, mc_busy, stall_count
  );
endinterface

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for a 5-stage pipeline with a multi-cycle execute unit,
// optional M/W-to-E forwarding and a saturating stall-cycle counter.
module hazard_ctrl_mc #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned FWD_EN = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_mc_if.slave bus
);

  localparam int unsigned     MC_W    = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
  localparam logic [MC_W-1:0] MC_LAST = MC_W'(MC_LAT - 1);
  localparam logic [REG_AW-1:0] R0    = '0;
  localparam logic            L_FWD   = (FWD_EN != 0);

  logic [MC_W-1:0]  r_mc_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_hit_e;
  logic             w_hit_m;
  logic             w_lw_stall;
  logic             w_raw_stall;
  logic             w_mc_stall;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;
  logic             w_stall_f;
  logic             w_stall_d;
  logic             w_stall_e;
  logic             w_flush_d;
  logic             w_flush_e;
  logic             w_flush_m;
  logic             w_mc_busy;

  // Bypass select for one E-stage source; M is younger so it wins over W.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic              rw_m,
    input logic [REG_AW-1:0] rd_m,
    input logic              rw_w,
    input logic [REG_AW-1:0] rd_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (rw_m && (rd_m != R0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (rw_w && (rd_w != R0) && (rd_w == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  // Hazard detection: D-stage sources against pending E/M writers and the multi-cycle unit.
  always_comb begin
    w_hit_e     = (bus.RdE != R0) && ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));
    w_hit_m     = (bus.RdM != R0) && ((bus.RdM == bus.Rs1D) || (bus.RdM == bus.Rs2D));
    w_lw_stall  = L_FWD && bus.LoadE && w_hit_e;
    // Without bypassing, any in-flight E/M writer blocks D; W writes the RF mid-cycle.
    w_raw_stall = !L_FWD && ((bus.RegWriteE && w_hit_e) || (bus.RegWriteM && w_hit_m));
    w_mc_stall  = bus.McStartE && (r_mc_cnt != MC_LAST);
  end

  // Operand bypass selects; they keep tracking M/W while E is held by the multi-cycle unit.
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (L_FWD) begin
      w_fwd_a = fwd_sel(bus.Rs1E, bus.RegWriteM, bus.RdM, bus.RegWriteW, bus.RdW);
      w_fwd_b = fwd_sel(bus.Rs2E, bus.RegWriteM, bus.RdM, bus.RegWriteW, bus.RdW);
    end
  end

  // Stall/flush priority: reset, multi-cycle hold, taken branch, data hazard.
  always_comb begin
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_e = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    w_flush_m = 1'b0;
    w_mc_busy = 1'b0;
    if (reset) begin
      w_flush_d = 1'b1;
      w_flush_e = 1'b1;
      w_flush_m = 1'b1;
    end else if (w_mc_stall) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_stall_e = 1'b1;
      w_flush_m = 1'b1;
      w_mc_busy = 1'b1;
    end else if (bus.PCSrcE) begin
      // The D instruction is discarded, so a hazard it carries is moot.
      w_flush_d = 1'b1;
      w_flush_e = 1'b1;
    end else if (w_lw_stall || w_raw_stall) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_flush_e = 1'b1;
    end
  end

  // Drive the bus; forwarding is forced to the register file while in reset.
  always_comb begin
    bus.ForwardAE   = reset ? 2'b00 : w_fwd_a;
    bus.ForwardBE   = reset ? 2'b00 : w_fwd_b;
    bus.StallF      = w_stall_f;
    bus.StallD      = w_stall_d;
    bus.StallE      = w_stall_e;
    bus.FlushD      = w_flush_d;
    bus.FlushE      = w_flush_e;
    bus.FlushM      = w_flush_m;
    bus.mc_busy     = w_mc_busy;
    bus.stall_count = r_stall_cnt;
  end

  // Multi-cycle occupancy counter; returns to zero on the release cycle or when the op leaves E.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mc_cnt <= '0;
    end else if (w_mc_stall) begin
      r_mc_cnt <= r_mc_cnt + 1'b1;
    end else begin
      r_mc_cnt <= '0;
    end
  end

  // Saturating count of fetch-stall cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall_f && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Scoreboard bench for hazard_ctrl_mc: three parameterisations share one stimulus stream,
// each directed vector names the instance it checks.
module tb_hazard_ctrl_mc;

  localparam logic [5:0] NONE = 6'b000000; // {StallF,StallD,StallE,FlushD,FlushE,FlushM}
  localparam logic [5:0] RSTF = 6'b000111;
  localparam logic [5:0] MCF  = 6'b111001;
  localparam logic [5:0] BRF  = 6'b000110;
  localparam logic [5:0] LWF  = 6'b110010;

  typedef struct {
    int         id;
    int         d;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [5:0] fl;
    logic       busy;
    int         cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic rwe, rwm, rww, loade, mcs, pcsrc;

  exp_t q[$];
  exp_t me;
  int   vid    = 0;
  int   n_vec  = 0;
  int   n_bad  = 0;

  always #5 clk = ~clk;

  hazard_ctrl_mc_if #(.REG_AW(5), .CNT_W(16)) if0 ();
  hazard_ctrl_mc_if #(.REG_AW(5), .CNT_W(4))  if1 ();
  hazard_ctrl_mc_if #(.REG_AW(5), .CNT_W(16)) if2 ();

  hazard_ctrl_mc #(.REG_AW(5), .MC_LAT(4), .FWD_EN(1), .CNT_W(16)) dut0 (.clk(clk), .reset(rst), .bus(if0.slave));
  hazard_ctrl_mc #(.REG_AW(5), .MC_LAT(1), .FWD_EN(1), .CNT_W(4))  dut1 (.clk(clk), .reset(rst), .bus(if1.slave));
  hazard_ctrl_mc #(.REG_AW(5), .MC_LAT(4), .FWD_EN(0), .CNT_W(16)) dut2 (.clk(clk), .reset(rst), .bus(if2.slave));

  // Fan the shared stimulus out to all instances.
  always_comb begin
    if0.Rs1D = rs1d; if0.Rs2D = rs2d; if0.Rs1E = rs1e; if0.Rs2E = rs2e;
    if0.RdE = rde; if0.RdM = rdm; if0.RdW = rdw;
    if0.RegWriteE = rwe; if0.RegWriteM = rwm; if0.RegWriteW = rww;
    if0.LoadE = loade; if0.McStartE = mcs; if0.PCSrcE = pcsrc;
    if1.Rs1D = rs1d; if1.Rs2D = rs2d; if1.Rs1E = rs1e; if1.Rs2E = rs2e;
    if1.RdE = rde; if1.RdM = rdm; if1.RdW = rdw;
    if1.RegWriteE = rwe; if1.RegWriteM = rwm; if1.RegWriteW = rww;
    if1.LoadE = loade; if1.McStartE = mcs; if1.PCSrcE = pcsrc;
    if2.Rs1D = rs1d; if2.Rs2D = rs2d; if2.Rs1E = rs1e; if2.Rs2E = rs2e;
    if2.RdE = rde; if2.RdM = rdm; if2.RdW = rdw;
    if2.RegWriteE = rwe; if2.RegWriteM = rwm; if2.RegWriteW = rww;
    if2.LoadE = loade; if2.McStartE = mcs; if2.PCSrcE = pcsrc;
  end

  task automatic clr();
    rs1d = '0; rs2d = '0; rs1e = '0; rs2e = '0; rde = '0; rdm = '0; rdw = '0;
    rwe = 1'b0; rwm = 1'b0; rww = 1'b0; loade = 1'b0; mcs = 1'b0; pcsrc = 1'b0;
  endtask

  // Queue the expected response for the inputs now applied, then advance one cycle.
  task automatic cyc(input int d, input logic [1:0] fa, input logic [1:0] fb,
                     input logic [5:0] fl, input logic busy, input int cnt);
    exp_t e;
    e.id = vid; e.d = d; e.fa = fa; e.fb = fb; e.fl = fl; e.busy = busy; e.cnt = cnt;
    vid++;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int d);
    rst = 1'b1;
    clr();
    cyc(d, 2'b00, 2'b00, RSTF, 1'b0, -1);
    cyc(d, 2'b00, 2'b00, RSTF, 1'b0, 0);
    rst = 1'b0;
  endtask

  // Monitor: mid-cycle, pop the oldest expectation and compare against the named instance.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      logic [1:0] afa, afb;
      logic [5:0] afl;
      logic       abusy;
      int         acnt;
      me = q.pop_front();
      case (me.d)
        0: begin
          afa = if0.ForwardAE; afb = if0.ForwardBE; abusy = if0.mc_busy; acnt = int'(if0.stall_count);
          afl = {if0.StallF, if0.StallD, if0.StallE, if0.FlushD, if0.FlushE, if0.FlushM};
        end
        1: begin
          afa = if1.ForwardAE; afb = if1.ForwardBE; abusy = if1.mc_busy; acnt = int'(if1.stall_count);
          afl = {if1.StallF, if1.StallD, if1.StallE, if1.FlushD, if1.FlushE, if1.FlushM};
        end
        default: begin
          afa = if2.ForwardAE; afb = if2.ForwardBE; abusy = if2.mc_busy; acnt = int'(if2.stall_count);
          afl = {if2.StallF, if2.StallD, if2.StallE, if2.FlushD, if2.FlushE, if2.FlushM};
        end
      endcase
      n_vec++;
      if (afa !== me.fa || afb !== me.fb || afl !== me.fl || abusy !== me.busy ||
          (me.cnt >= 0 && acnt != me.cnt)) begin
        n_bad++;
        $display("FAIL vec%0d dut%0d: fwdA %b/%b fwdB %b/%b stall_flush %b/%b busy %b/%b count %0d/%0d (got/want)",
                 me.id, me.d, afa, me.fa, afb, me.fb, afl, me.fl, abusy, me.busy, acnt, me.cnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    clr();
    @(posedge clk);
    #1;
    do_reset(0);

    // Forwarding priority on instance 0
    clr(); rs1e = 5'd5; rdm = 5'd5; rwm = 1'b1; rdw = 5'd5; rww = 1'b1;
    cyc(0, 2'b10, 2'b00, NONE, 1'b0, 0);
    rwm = 1'b0;
    cyc(0, 2'b01, 2'b00, NONE, 1'b0, 0);
    rdm = 5'd0; rdw = 5'd0; rwm = 1'b1;
    cyc(0, 2'b00, 2'b00, NONE, 1'b0, 0);
    clr(); rs1e = 5'd4; rs2e = 5'd9; rdm = 5'd9; rwm = 1'b1; rdw = 5'd4; rww = 1'b1;
    cyc(0, 2'b01, 2'b10, NONE, 1'b0, 0);

    // Load-use, then the same with RdE=0
    clr(); loade = 1'b1; rwe = 1'b1; rde = 5'd7; rs2d = 5'd7;
    cyc(0, 2'b00, 2'b00, LWF, 1'b0, 0);
    clr();
    cyc(0, 2'b00, 2'b00, NONE, 1'b0, 1);
    loade = 1'b1; rwe = 1'b1; rde = 5'd0; rs2d = 5'd7;
    cyc(0, 2'b00, 2'b00, NONE, 1'b0, 1);

    // Taken branch overrides load-use
    clr(); loade = 1'b1; rwe = 1'b1; rde = 5'd7; rs1d = 5'd7; pcsrc = 1'b1;
    cyc(0, 2'b00, 2'b00, BRF, 1'b0, 1);
    clr();
    cyc(0, 2'b00, 2'b00, NONE, 1'b0, 1);

    // Multi-cycle op, MC_LAT=4: three stall cycles then release
    mcs = 1'b1;
    cyc(0, 2'b00, 2'b00, MCF, 1'b1, 1);
    cyc(0, 2'b00, 2'b00, MCF, 1'b1, 2);
    cyc(0, 2'b00, 2'b00, MCF, 1'b1, 3);
    cyc(0, 2'b00, 2'b00, NONE, 1'b0, 4);
    clr();
    cyc(0, 2'b00, 2'b00, NONE, 1'b0, 4);
    // Second op: bypass during hold, and hold beats branch and load-use
    mcs = 1'b1; rs1e = 5'd3; rdm = 5'd3; rwm = 1'b1;
    cyc(0, 2'b10, 2'b00, MCF, 1'b1, 4);
    loade = 1'b1; rwe = 1'b1; rde = 5'd7; rs1d = 5'd7; pcsrc = 1'b1;
    cyc(0, 2'b10, 2'b00, MCF, 1'b1, 5);
    clr(); mcs = 1'b1;
    cyc(0, 2'b00, 2'b00, MCF, 1'b1, 6);
    cyc(0, 2'b00, 2'b00, NONE, 1'b0, 7);
    clr();
    cyc(0, 2'b00, 2'b00, NONE, 1'b0, 7);

    // Reset in cycle 2 of an op aborts it; a fresh op then stalls a full three cycles
    mcs = 1'b1;
    cyc(0, 2'b00, 2'b00, MCF, 1'b1, 7);
    rst = 1'b1;
    cyc(0, 2'b00, 2'b00, RSTF, 1'b0, 8);
    rst = 1'b0;
    cyc(0, 2'b00, 2'b00, MCF, 1'b1, 0);
    cyc(0, 2'b00, 2'b00, MCF, 1'b1, 1);
    cyc(0, 2'b00, 2'b00, MCF, 1'b1, 2);
    cyc(0, 2'b00, 2'b00, NONE, 1'b0, 3);

    // MC_LAT=1 never stalls; CNT_W=4 saturates at 15
    do_reset(1);
    mcs = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1, 2'b00, 2'b00, NONE, 1'b0, 0);
    clr(); loade = 1'b1; rwe = 1'b1; rde = 5'd7; rs1d = 5'd7;
    for (int i = 0; i < 20; i++) cyc(1, 2'b00, 2'b00, LWF, 1'b0, (i < 15) ? i : 15);
    clr();
    cyc(1, 2'b00, 2'b00, NONE, 1'b0, 15);

    // Forwarding disabled: E/M writers stall D, W does not, bypass stays 00
    do_reset(2);
    rwm = 1'b1; rdm = 5'd3; rs1d = 5'd3; rs1e = 5'd3;
    cyc(2, 2'b00, 2'b00, LWF, 1'b0, 0);
    clr(); rww = 1'b1; rdw = 5'd3; rs1d = 5'd3; rs1e = 5'd3;
    cyc(2, 2'b00, 2'b00, NONE, 1'b0, 1);
    clr(); rwe = 1'b1; rde = 5'd6; rs2d = 5'd6;
    cyc(2, 2'b00, 2'b00, LWF, 1'b0, 1);
    clr(); rwe = 1'b1; rwm = 1'b1;
    cyc(2, 2'b00, 2'b00, NONE, 1'b0, 2);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
